// File: rtl/wishbone_slave_to_rtsnoc_mt.sv
// Wishbone slave bridging one address window onto N_TGT RTSNoC nodes, one transaction in flight.
// Optional read-response timeout enabled by defining RTSNOC_WB_TIMEOUT_EN.
module wishbone_slave_to_rtsnoc_mt #(
    parameter int                  WB_ADDR_WIDTH     = 6,
    parameter int                  WB_NOC_DATA_WIDTH = 32,
    parameter logic [2:0]          NOC_LOCAL_ADR     = 3'd0,
    parameter int                  SOC_SIZE_X        = 1,
    parameter int                  SOC_SIZE_Y        = 1,
    parameter logic [SOC_SIZE_X-1:0] NOC_X           = '0,
    parameter logic [SOC_SIZE_Y-1:0] NOC_Y           = '0,
    parameter int                  N_TGT             = 2,
    parameter logic [N_TGT*(SOC_SIZE_X+SOC_SIZE_Y+3)-1:0] TGT_MAP = '0,
    parameter int                  TIMEOUT_CYCLES    = 255,
    localparam int TGT_SEL_W       = (N_TGT > 1) ? $clog2(N_TGT) : 1,
    localparam int NOC_HEADER_SIZE = 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6,
    localparam int NOC_BUS_SIZE    = WB_NOC_DATA_WIDTH + NOC_HEADER_SIZE
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic [WB_ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [3:0]                   wb_sel_i,
    input  logic                         wb_we_i,
    input  logic [WB_NOC_DATA_WIDTH-1:0] wb_dat_i,
    output logic [WB_NOC_DATA_WIDTH-1:0] wb_dat_o,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic [N_TGT-1:0]             noc_int_o,
    output logic [NOC_BUS_SIZE-1:0]      noc_din_o,
    output logic                         noc_wr_o,
    output logic                         noc_rd_o,
    input  logic [NOC_BUS_SIZE-1:0]      noc_dout_i,
    input  logic                         noc_wait_i,
    input  logic                         noc_nd_i
);

    localparam int W       = WB_NOC_DATA_WIDTH;
    localparam int E       = SOC_SIZE_X + SOC_SIZE_Y + 3;
    localparam int RA_W    = WB_ADDR_WIDTH - TGT_SEL_W;
    localparam int IRQ_BIT = W - 6;
    localparam logic [E-1:0] ORIG = {NOC_X, NOC_Y, NOC_LOCAL_ADR};

    typedef enum logic [3:0] {
        IDLE, SEND_CMD, WAIT_CMD, SEND_DAT, WAIT_DAT, WAIT_RSP, LOCAL, ACK, ERR
    } state_t;

    state_t                 r_state, w_next;
    logic [TGT_SEL_W-1:0]   r_tgt;
    logic [RA_W-1:0]        r_radr;
    logic [3:0]             r_sel;
    logic                   r_we;
    logic [W-1:0]           r_dat;
    logic                   r_bad;
    logic                   r_rd;
    logic [W-1:0]           r_rdata;
    logic [N_TGT-1:0]       r_int;

    logic                   w_req;
    logic [TGT_SEL_W-1:0]   w_in_tgt;
    logic [RA_W-1:0]        w_in_radr;
    logic                   w_in_bad;
    logic                   w_in_local;
    logic [E-1:0]           w_rx_orig;
    logic [W-1:0]           w_rx_pay;
    logic [E-1:0]           w_dst;
    logic [W-1:0]           w_cmd;
    logic                   w_rsp_hit;
    logic                   w_tmo;
    logic [N_TGT-1:0]       w_int_set;
    logic [N_TGT-1:0]       w_int_clr;
    logic                   w_unused;

    assign w_req      = wb_cyc_i & wb_stb_i;
    assign w_in_tgt   = wb_adr_i[WB_ADDR_WIDTH-1 -: TGT_SEL_W];
    assign w_in_radr  = wb_adr_i[RA_W-1:0];
    assign w_in_bad   = (32'(w_in_tgt) >= 32'(N_TGT));
    // All-ones remote address on a write is the local interrupt-clear register.
    assign w_in_local = wb_we_i & (&w_in_radr);

    assign w_rx_orig  = noc_dout_i[NOC_BUS_SIZE-1 -: E];
    assign w_rx_pay   = noc_dout_i[W-1:0];

    always_comb begin
        w_dst = '0;
        for (int i = 0; i < N_TGT; i++)
            if (r_tgt == TGT_SEL_W'(i)) w_dst = TGT_MAP[i*E +: E];
    end

    always_comb begin
        w_cmd              = '0;
        w_cmd[W-1]         = r_we;
        w_cmd[W-2 -: 4]    = r_sel;
        w_cmd[RA_W-1:0]    = r_radr;
    end

    assign w_rsp_hit = r_rd && (r_state == WAIT_RSP) && (w_rx_orig == w_dst);

    // A matching read response takes priority over treating the flit as an interrupt.
    always_comb begin
        w_int_set = '0;
        w_int_clr = '0;
        for (int i = 0; i < N_TGT; i++) begin
            w_int_set[i] = r_rd && w_rx_pay[IRQ_BIT] && !w_rsp_hit &&
                           (w_rx_orig == TGT_MAP[i*E +: E]);
            w_int_clr[i] = (r_state == LOCAL) && !r_bad && (r_tgt == TGT_SEL_W'(i));
        end
    end

`ifdef RTSNOC_WB_TIMEOUT_EN
    logic [15:0] r_tmo;

    always_ff @(posedge clk_i) begin
        if (!rst_i)                   r_tmo <= '0;
        else if (r_state == WAIT_RSP) r_tmo <= r_tmo + 16'd1;
        else                          r_tmo <= '0;
    end

    assign w_tmo    = (r_state == WAIT_RSP) && !w_rsp_hit && (r_tmo == 16'(TIMEOUT_CYCLES - 1));
    assign w_unused = ^noc_dout_i[W+E-1:W];
`else
    assign w_tmo    = 1'b0;
    assign w_unused = ^{noc_dout_i[W+E-1:W], 16'(TIMEOUT_CYCLES)};
`endif

    always_comb begin
        w_next    = r_state;
        wb_ack_o  = 1'b0;
        wb_err_o  = 1'b0;
        noc_wr_o  = 1'b0;
        noc_din_o = '0;
        unique case (r_state)
            IDLE:     if (w_req) w_next = (w_in_bad || w_in_local) ? LOCAL : SEND_CMD;
            SEND_CMD: begin
                noc_wr_o  = 1'b1;
                noc_din_o = {ORIG, w_dst, w_cmd};
                w_next    = WAIT_CMD;
            end
            WAIT_CMD: begin
                noc_din_o = {ORIG, w_dst, w_cmd};
                if (!noc_wait_i) w_next = r_we ? SEND_DAT : WAIT_RSP;
            end
            SEND_DAT: begin
                noc_wr_o  = 1'b1;
                noc_din_o = {ORIG, w_dst, r_dat};
                w_next    = WAIT_DAT;
            end
            WAIT_DAT: begin
                noc_din_o = {ORIG, w_dst, r_dat};
                if (!noc_wait_i) w_next = ACK;
            end
            WAIT_RSP: begin
                if (w_rsp_hit)  w_next = ACK;
                else if (w_tmo) w_next = ERR;
            end
            LOCAL:    w_next = r_bad ? ERR : ACK;
            ACK: begin
                wb_ack_o = 1'b1;
                w_next   = IDLE;
            end
            ERR: begin
                wb_err_o = 1'b1;
                w_next   = IDLE;
            end
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_tgt   <= '0;
            r_radr  <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_dat   <= '0;
            r_bad   <= 1'b0;
            r_rd    <= 1'b0;
            r_rdata <= '0;
            r_int   <= '0;
        end else begin
            r_state <= w_next;
            // One consume strobe per new-data indication, even if nd lingers a cycle.
            r_rd    <= noc_nd_i & ~r_rd;
            r_int   <= (r_int & ~w_int_clr) | w_int_set;
            if (r_state == IDLE && w_req) begin
                r_tgt  <= w_in_tgt;
                r_radr <= w_in_radr;
                r_sel  <= wb_sel_i;
                r_we   <= wb_we_i;
                r_dat  <= wb_dat_i;
                r_bad  <= w_in_bad;
            end
            if (w_rsp_hit)  r_rdata <= w_rx_pay;
            else if (w_tmo) r_rdata <= '1;
        end
    end

    assign wb_dat_o  = r_rdata;
    assign noc_rd_o  = r_rd;
    assign noc_int_o = r_int;

endmodule

// File: tb/tb_wishbone_slave_to_rtsnoc_mt.sv
// Directed bench for wishbone_slave_to_rtsnoc_mt with a flit scoreboard on noc_wr_o.
module tb_wishbone_slave_to_rtsnoc_mt;
    localparam logic [9:0] MAP = {5'b10010, 5'b00001};
    localparam logic [4:0] T0  = 5'b00001;
    localparam logic [4:0] T1  = 5'b10010;
    localparam logic [4:0] ORG = 5'b00000;
`ifdef RTSNOC_WB_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 255;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [5:0]  wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i, wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [1:0]  noc_int_o;
    logic [41:0] noc_din_o, noc_dout_i;
    logic        noc_wr_o, noc_rd_o, noc_wait_i, noc_nd_i;

    logic [31:0] e1_dat;
    logic        e1_ack, e1_err, e1_wr, e1_rd;
    logic [0:0]  e1_int;
    logic [41:0] e1_din;

    int n_chk = 0, n_fail = 0;
    int n_ack = 0, n_err = 0, n_wr = 0, n_rd = 0, n1_err = 0, n1_wr = 0;
    logic [41:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    wishbone_slave_to_rtsnoc_mt #(.N_TGT(2), .TGT_MAP(MAP), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .noc_int_o(noc_int_o),
        .noc_din_o(noc_din_o), .noc_wr_o(noc_wr_o), .noc_rd_o(noc_rd_o),
        .noc_dout_i(noc_dout_i), .noc_wait_i(noc_wait_i), .noc_nd_i(noc_nd_i));

    // Single-target instance: address MSB set means an unmapped target index.
    wishbone_slave_to_rtsnoc_mt #(.N_TGT(1), .TGT_MAP(T0), .TIMEOUT_CYCLES(TMO)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(e1_dat), .wb_ack_o(e1_ack), .wb_err_o(e1_err), .noc_int_o(e1_int),
        .noc_din_o(e1_din), .noc_wr_o(e1_wr), .noc_rd_o(e1_rd),
        .noc_dout_i(noc_dout_i), .noc_wait_i(noc_wait_i), .noc_nd_i(noc_nd_i));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [41:0] fl(input logic [4:0] o, input logic [4:0] d, input logic [31:0] p);
        return {o, d, p};
    endfunction

    always @(negedge clk_i) begin
        if (wb_ack_o) n_ack++;
        if (wb_err_o) n_err++;
        if (noc_rd_o) n_rd++;
        if (e1_err)   n1_err++;
        if (e1_wr)    n1_wr++;
        if (noc_wr_o) begin
            n_wr++;
            chk("sb_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) chk("sb_flit", 64'(noc_din_o), 64'(exp_q.pop_front()));
        end
    end

    task automatic wb_req(input logic [5:0] adr, input logic we, input logic [31:0] dat);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = adr; wb_we_i = we;
        wb_sel_i = 4'hF; wb_dat_i = dat;
        @(negedge clk_i);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    task automatic send_flit(input logic [41:0] f);
        @(negedge clk_i);
        noc_nd_i = 1'b1; noc_dout_i = f;
        @(negedge clk_i);
        noc_nd_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int lat);
        lat = 0;
        while (!(wb_ack_o || wb_err_o) && lat < budget) begin
            @(negedge clk_i);
            lat++;
        end
        chk(tag, 64'(lat < budget), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, a0, r0, w0, e0;
        logic [41:0] saved;
        rst_i = 1'b0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0;
        wb_sel_i = '0; wb_dat_i = '0; noc_dout_i = '0; noc_wait_i = 0; noc_nd_i = 0;
        repeat (3) @(negedge clk_i);
        chk("reset_outs", 64'({wb_ack_o, wb_err_o, noc_wr_o, noc_rd_o, noc_int_o, wb_dat_o}), 64'(0));
        chk("reset_din", 64'(noc_din_o), 64'(0));
        rst_i = 1'b1;
        @(negedge clk_i);

        // Posted write to target 0
        a0 = n_ack; w0 = n_wr;
        exp_q.push_back(fl(ORG, T0, 32'hF8000003));
        exp_q.push_back(fl(ORG, T0, 32'hAABBCCDD));
        wb_req(6'b0_00011, 1'b1, 32'hAABBCCDD);
        wait_done("wr_done", 20, lat);
        chk("wr_lat", 64'(lat), 64'(4));
        repeat (3) @(negedge clk_i);
        chk("wr_acks", 64'(n_ack - a0), 64'(1));
        chk("wr_flits", 64'(n_wr - w0), 64'(2));

        // Read from target 1; single-target instance must error on the same access
        a0 = n_ack; r0 = n_rd; e0 = n1_err; w0 = n1_wr;
        exp_q.push_back(fl(ORG, T1, 32'h78000002));
        wb_req(6'b1_00010, 1'b0, 32'h0);
        chk("bad_err_c1", 64'(e1_err), 64'(0));
        @(negedge clk_i);
        chk("bad_err_c2", 64'(e1_err), 64'(1));
        repeat (3) @(negedge clk_i);
        send_flit(fl(T1, ORG, 32'hEEEEFFFF));
        wait_done("rd_done", 20, lat);
        chk("rd_data", 64'(wb_dat_o), 64'(32'hEEEEFFFF));
        repeat (3) @(negedge clk_i);
        chk("rd_acks", 64'(n_ack - a0), 64'(1));
        chk("rd_strobes", 64'(n_rd - r0), 64'(1));
        chk("bad_errs", 64'(n1_err - e0), 64'(1));
        chk("bad_no_traffic", 64'(n1_wr - w0), 64'(0));
        chk("rd_data_hold", 64'(wb_dat_o), 64'(32'hEEEEFFFF));

        // Router busy for 10 cycles after the command flit
        a0 = n_ack; w0 = n_wr;
        noc_wait_i = 1'b1;
        exp_q.push_back(fl(ORG, T0, 32'hF8000001));
        exp_q.push_back(fl(ORG, T0, 32'h12345678));
        wb_req(6'b0_00001, 1'b1, 32'h12345678);
        chk("wait_wr_pulse", 64'(noc_wr_o), 64'(1));
        saved = noc_din_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("wait_hold", 64'({noc_wr_o, wb_ack_o, noc_din_o}), 64'({2'b00, saved}));
        end
        noc_wait_i = 1'b0;
        wait_done("wait_done", 20, lat);
        chk("wait_lat", 64'(lat), 64'(3));
        repeat (3) @(negedge clk_i);
        chk("wait_acks", 64'(n_ack - a0), 64'(1));
        chk("wait_flits", 64'(n_wr - w0), 64'(2));

        // Interrupts: mapped origin sets its flag, others are dropped, local write clears
        send_flit(fl(T1, ORG, 32'h04000000));
        @(negedge clk_i);
        chk("irq_set", 64'(noc_int_o), 64'(2'b10));
        send_flit(fl(5'b11111, ORG, 32'h04000000));
        send_flit(fl(T0, ORG, 32'h00000000));
        repeat (2) @(negedge clk_i);
        chk("irq_drop", 64'(noc_int_o), 64'(2'b10));
        a0 = n_ack; w0 = n_wr;
        wb_req(6'b1_11111, 1'b1, 32'h0);
        wait_done("irq_clr_done", 10, lat);
        chk("irq_clr_lat", 64'(lat), 64'(1));
        chk("irq_clr", 64'(noc_int_o), 64'(0));
        repeat (2) @(negedge clk_i);
        chk("irq_clr_acks", 64'(n_ack - a0), 64'(1));
        chk("irq_clr_no_noc", 64'(n_wr - w0), 64'(0));

        // Reset in the middle of a read, then a clean read
        exp_q.push_back(fl(ORG, T0, 32'h78000005));
        wb_req(6'b0_00101, 1'b0, 32'h0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_outs", 64'({wb_ack_o, wb_err_o, noc_wr_o, noc_rd_o, noc_int_o, wb_dat_o}), 64'(0));
        chk("rst_mid_din", 64'(noc_din_o), 64'(0));
        rst_i = 1'b1;
        a0 = n_ack;
        exp_q.push_back(fl(ORG, T0, 32'h78000006));
        wb_req(6'b0_00110, 1'b0, 32'h0);
        repeat (2) @(negedge clk_i);
        send_flit(fl(T0, ORG, 32'h13572468));
        wait_done("post_rst_done", 20, lat);
        chk("post_rst_data", 64'(wb_dat_o), 64'(32'h13572468));
        repeat (2) @(negedge clk_i);
        chk("post_rst_acks", 64'(n_ack - a0), 64'(1));

`ifdef RTSNOC_WB_TIMEOUT_EN
        a0 = n_ack; e0 = n_err;
        exp_q.push_back(fl(ORG, T1, 32'h78000001));
        wb_req(6'b1_00001, 1'b0, 32'h0);
        wait_done("tmo_done", 60, lat);
        chk("tmo_err", 64'(wb_err_o), 64'(1));
        chk("tmo_lat", 64'(lat), 64'(22));
        chk("tmo_data", 64'(wb_dat_o), 64'(32'hFFFFFFFF));
        repeat (6) @(negedge clk_i);
        send_flit(fl(T1, ORG, 32'h55555555));
        repeat (3) @(negedge clk_i);
        chk("tmo_late_acks", 64'(n_ack - a0), 64'(0));
        chk("tmo_errs", 64'(n_err - e0), 64'(1));
        chk("tmo_late_data", 64'(wb_dat_o), 64'(32'hFFFFFFFF));
`endif

        chk("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
